farm_sensor_monitor: RTL and testbench

- Multi-channel sensor threshold monitor for the precision-farming ASIC. Generalises the single-input alert path to NUM_CH time-multiplexed channels.
- Per-channel programmable thresholds, above/below mode, hysteresis and debounce.
- Aggregates channels into a 3-bit alert level and a harvest alert.
- Per-channel sample-timeout watchdog raises a sticky fault.
- Sits between the sensor/camera input mux and the status-LED/buzzer outputs.

---
 rtl/farm_sensor_monitor.sv | 124 ++++++++++++
 tb/tb_farm_sensor_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/farm_sensor_monitor.sv
// Multi-channel sensor threshold monitor: per-channel debounced alerts with hysteresis,
// aggregated alert level / harvest alert, and sticky per-channel sample-timeout faults.
module farm_sensor_monitor #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 8,
  parameter int DEBOUNCE   = 4,
  parameter int HYST       = 4,
  parameter int THRESH_RST = 128,
  parameter int TIMEOUT    = 64,
  parameter int ALERT_MIN  = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_thresh,
  input  logic              mode_below,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] alert_ch,
  output logic [2:0]        alert_level,
  output logic              harvest_alert,
  output logic [NUM_CH-1:0] fault_ch,
  output logic              fault
);

  localparam int CNT_W = 4;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int CMP_W = DATA_W + 2;
  localparam logic [CH_W:0]  CH_LIM  = (CH_W + 1)'(NUM_CH);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  logic [DATA_W-1:0] thresh [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [WD_W-1:0]   wd     [NUM_CH];
  logic              mode_prev;

  logic              sample_ok, cfg_ok, mode_chg;
  logic [CMP_W-1:0]  x_w, t_w, h_w;
  logic              trip_hit, rel_hit, qual, deb_hit;
  logic [CNT_W-1:0]  cnt_base, cnt_inc;
  logic [3:0]        ones;
  logic [2:0]        level_sat;
  logic              harvest_next;

  assign sample_ok = sample_valid && ({1'b0, sample_ch} < CH_LIM);
  assign cfg_ok    = cfg_we && ({1'b0, cfg_ch} < CH_LIM);
  assign mode_chg  = mode_below != mode_prev;

  // Widened compare: x + HYST < T and x > T + HYST give the saturating band edges for free.
  assign x_w      = CMP_W'(sample_data);
  assign t_w      = CMP_W'(thresh[sample_ch]);
  assign h_w      = CMP_W'(HYST);
  assign trip_hit = mode_below ? (x_w < t_w) : (x_w > t_w);
  assign rel_hit  = mode_below ? (x_w > t_w + h_w) : (x_w + h_w < t_w);

  assign qual     = alert_ch[sample_ch] ? rel_hit : trip_hit;
  assign cnt_base = mode_chg ? '0 : cnt[sample_ch];
  assign cnt_inc  = cnt_base + CNT_W'(1);
  assign deb_hit  = qual && (cnt_inc == CNT_W'(DEBOUNCE));

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ones = '0;
    for (int c = 0; c < NUM_CH; c++) ones = ones + 4'(alert_ch[c]);
  end

  assign level_sat    = (ones > 4'd7) ? 3'd7 : ones[2:0];
  assign harvest_next = {1'b0, level_sat} >= 4'(ALERT_MIN);

  // NOTE: state uses non-blocking assignments only; the threshold array is reset, so it maps to flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        thresh[c] <= DATA_W'(THRESH_RST);
        cnt[c]    <= '0;
        wd[c]     <= '0;
      end
      alert_ch      <= '0;
      fault_ch      <= '0;
      mode_prev     <= 1'b0;
      alert_level   <= '0;
      harvest_alert <= 1'b0;
      fault         <= 1'b0;
    end else begin
      mode_prev     <= mode_below;
      alert_level   <= level_sat;
      harvest_alert <= harvest_next;
      fault         <= |fault_ch;

      if (cfg_ok) thresh[cfg_ch] <= cfg_thresh;

      for (int c = 0; c < NUM_CH; c++) begin
        if (sample_ok && (sample_ch == CH_W'(c))) begin
          if (!qual) begin
            cnt[c] <= '0;
          end else if (deb_hit) begin
            cnt[c]      <= '0;
            alert_ch[c] <= ~alert_ch[c];
          end else begin
            cnt[c] <= cnt_inc;
          end
        end else if (mode_chg) begin
          cnt[c] <= '0;
        end

        // Clear beats both the sample restart and a simultaneous timeout.
        if (fault_clr) begin
          wd[c]       <= '0;
          fault_ch[c] <= 1'b0;
        end else if (sample_ok && (sample_ch == CH_W'(c))) begin
          wd[c] <= '0;
        end else if (wd[c] != WD_MAX) begin
          wd[c] <= wd[c] + WD_W'(1);
          if (wd[c] + WD_W'(1) == WD_MAX) fault_ch[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_farm_sensor_monitor.sv
// Bench for farm_sensor_monitor: directed scenarios plus randomized traffic against
// a behavioural channel model kept in plain integers.
module tb_farm_sensor_monitor;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 8;
  localparam int DEBOUNCE   = 4;
  localparam int HYST       = 4;
  localparam int THRESH_RST = 128;
  localparam int TIMEOUT    = 64;
  localparam int ALERT_MIN  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] sample_ch = '0;
  logic [7:0] sample_data = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_thresh = '0;
  logic       mode_below = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] alert_ch;
  logic [2:0] alert_level;
  logic       harvest_alert;
  logic [3:0] fault_ch;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;
  logic cur_mode = 1'b0;

  // Behavioural model state
  int         m_thr [NUM_CH];
  int         m_cnt [NUM_CH];
  int         m_wd  [NUM_CH];
  logic [3:0] m_alert, m_fault_ch;
  logic       m_prev_mode, m_harvest, m_fault;
  int         m_level;

  farm_sensor_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEBOUNCE(DEBOUNCE), .HYST(HYST),
    .THRESH_RST(THRESH_RST), .TIMEOUT(TIMEOUT), .ALERT_MIN(ALERT_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thresh(cfg_thresh),
    .mode_below(mode_below), .fault_clr(fault_clr),
    .alert_ch(alert_ch), .alert_level(alert_level), .harvest_alert(harvest_alert),
    .fault_ch(fault_ch), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_thr[c] = THRESH_RST;
      m_cnt[c] = 0;
      m_wd[c]  = 0;
    end
    m_alert = '0; m_fault_ch = '0; m_prev_mode = 1'b0;
    m_level = 0; m_harvest = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic v, input int ch, input int d, input logic we,
                            input int cch, input int cth, input logic m, input logic clr);
    int  pc, nl, t, lo, hi;
    logic nh, nf, acc, trip, rel, q;
    pc = $countones(m_alert);
    nl = (pc > 7) ? 7 : pc;
    nh = (nl >= ALERT_MIN);
    nf = |m_fault_ch;
    if (m != m_prev_mode) for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
    m_prev_mode = m;
    acc = v && (ch < NUM_CH);
    if (acc) begin
      t = m_thr[ch];
      if (!m) begin
        trip = d > t;
        lo   = t - HYST;
        rel  = (lo >= 0) && (d < lo);
      end else begin
        trip = d < t;
        hi   = (t + HYST > 255) ? 255 : t + HYST;
        rel  = d > hi;
      end
      q = m_alert[ch] ? rel : trip;
      if (q) begin
        m_cnt[ch] = m_cnt[ch] + 1;
        if (m_cnt[ch] == DEBOUNCE) begin
          m_alert[ch] = ~m_alert[ch];
          m_cnt[ch]   = 0;
        end
      end else begin
        m_cnt[ch] = 0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr) begin
        m_wd[c] = 0;
        m_fault_ch[c] = 1'b0;
      end else begin
        if (acc && ch == c) m_wd[c] = 0;
        else if (m_wd[c] < TIMEOUT) m_wd[c] = m_wd[c] + 1;
        if (m_wd[c] == TIMEOUT) m_fault_ch[c] = 1'b1;
      end
    end
    if (we && cch < NUM_CH) m_thr[cch] = cth;
    m_level = nl; m_harvest = nh; m_fault = nf;
  endtask

  task automatic cyc(input logic v, input int ch, input int d, input logic we,
                     input int cch, input int cth, input logic clr);
    sample_valid = v;  sample_ch = ch[1:0];  sample_data = d[7:0];
    cfg_we = we;       cfg_ch = cch[1:0];    cfg_thresh = cth[7:0];
    mode_below = cur_mode;  fault_clr = clr;
    @(posedge clk);
    model_step(v, ch, d, we, cch, cth, cur_mode, clr);
    #1;
    sample_valid = 1'b0; cfg_we = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic smp(input int ch, input int d);
    cyc(1'b1, ch, d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks += 5;
    if (alert_ch !== 4'b0) begin n_fail++; $display("FAIL reset_alert_ch got %b want 0000", alert_ch); end
    if (alert_level !== 3'd0) begin n_fail++; $display("FAIL reset_alert_level got %0d want 0", alert_level); end
    if (harvest_alert !== 1'b0) begin n_fail++; $display("FAIL reset_harvest got %b want 0", harvest_alert); end
    if (fault_ch !== 4'b0) begin n_fail++; $display("FAIL reset_fault_ch got %b want 0000", fault_ch); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alert_basic();
    for (int i = 0; i < 3; i++) smp(1, 200);
    n_checks++;
    if (alert_ch !== 4'b0000) begin n_fail++; $display("FAIL t1_before_4th got %b want 0000", alert_ch); end
    smp(1, 200);
    n_checks += 2;
    if (alert_ch !== 4'b0010) begin n_fail++; $display("FAIL t1_alert_ch got %b want 0010", alert_ch); end
    if (alert_level !== 3'd0) begin n_fail++; $display("FAIL t1_level_early got %0d want 0", alert_level); end
    idle();
    n_checks += 2;
    if (alert_level !== 3'd1) begin n_fail++; $display("FAIL t1_level got %0d want 1", alert_level); end
    if (harvest_alert !== 1'b0) begin n_fail++; $display("FAIL t1_harvest got %b want 0", harvest_alert); end
  endtask

  task automatic test_band_release();
    for (int i = 0; i < 4; i++) smp(3, 200);
    n_checks++;
    if (alert_ch !== 4'b1010) begin n_fail++; $display("FAIL t2_ch3_set got %b want 1010", alert_ch); end
    idle();
    n_checks += 2;
    if (alert_level !== 3'd2) begin n_fail++; $display("FAIL t2_level2 got %0d want 2", alert_level); end
    if (harvest_alert !== 1'b1) begin n_fail++; $display("FAIL t2_harvest_on got %b want 1", harvest_alert); end
    for (int i = 0; i < 4; i++) smp(1, 126);
    n_checks++;
    if (alert_ch !== 4'b1010) begin n_fail++; $display("FAIL t2_band_hold got %b want 1010", alert_ch); end
    for (int i = 0; i < 3; i++) smp(1, 120);
    n_checks++;
    if (alert_ch !== 4'b1010) begin n_fail++; $display("FAIL t2_release_early got %b want 1010", alert_ch); end
    smp(1, 120);
    n_checks++;
    if (alert_ch !== 4'b1000) begin n_fail++; $display("FAIL t2_release got %b want 1000", alert_ch); end
    idle();
    n_checks += 2;
    if (alert_level !== 3'd1) begin n_fail++; $display("FAIL t2_level1 got %0d want 1", alert_level); end
    if (harvest_alert !== 1'b0) begin n_fail++; $display("FAIL t2_harvest_off got %b want 0", harvest_alert); end
  endtask

  task automatic test_interrupted();
    for (int i = 0; i < 3; i++) smp(0, 200);
    smp(0, 100);
    for (int i = 0; i < 3; i++) smp(0, 200);
    n_checks++;
    if (alert_ch[0] !== 1'b0) begin n_fail++; $display("FAIL t3_interrupted got %b want 0", alert_ch[0]); end
    smp(0, 200);
    n_checks++;
    if (alert_ch[0] !== 1'b1) begin n_fail++; $display("FAIL t3_set got %b want 1", alert_ch[0]); end
  endtask

  task automatic test_config();
    cur_mode = 1'b1;
    cyc(1'b1, 2, 40, 1'b1, 2, 50, 1'b0);
    n_checks++;
    if (alert_ch !== 4'b1001) begin n_fail++; $display("FAIL t4_mode_hold got %b want 1001", alert_ch); end
    for (int i = 0; i < 2; i++) smp(2, 40);
    n_checks++;
    if (alert_ch[2] !== 1'b0) begin n_fail++; $display("FAIL t4_early got %b want 0", alert_ch[2]); end
    smp(2, 40);
    n_checks++;
    if (alert_ch[2] !== 1'b1) begin n_fail++; $display("FAIL t4_set_old_thresh got %b want 1", alert_ch[2]); end
    smp(2, 40);
    for (int i = 0; i < 3; i++) smp(2, 60);
    n_checks++;
    if (alert_ch[2] !== 1'b1) begin n_fail++; $display("FAIL t4_no_clear_yet got %b want 1", alert_ch[2]); end
    smp(2, 60);
    n_checks++;
    if (alert_ch !== 4'b1001) begin n_fail++; $display("FAIL t4_clear got %b want 1001", alert_ch); end
  endtask

  task automatic test_watchdog();
    cur_mode = 1'b0;
    cyc(1'b1, 0, 100, 1'b0, 0, 0, 1'b1);
    n_checks++;
    if (fault_ch !== 4'b0000) begin n_fail++; $display("FAIL t5_clr got %b want 0000", fault_ch); end
    for (int i = 1; i <= 65; i++) begin
      cyc(i % 10 == 0, 0, 100, 1'b0, 0, 0, 1'b0);
      if (i == 63) begin
        n_checks++;
        if (fault_ch !== 4'b0000) begin n_fail++; $display("FAIL t5_pre_timeout got %b want 0000", fault_ch); end
      end
      if (i == 64) begin
        n_checks += 2;
        if (fault_ch !== 4'b1110) begin n_fail++; $display("FAIL t5_timeout got %b want 1110", fault_ch); end
        if (fault !== 1'b0) begin n_fail++; $display("FAIL t5_fault_early got %b want 0", fault); end
      end
      if (i == 65) begin
        n_checks++;
        if (fault !== 1'b1) begin n_fail++; $display("FAIL t5_fault got %b want 1", fault); end
      end
    end
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    n_checks++;
    if (fault_ch !== 4'b0000) begin n_fail++; $display("FAIL t5_clr2 got %b want 0000", fault_ch); end
    for (int j = 1; j <= 65; j++) begin
      cyc(j % 10 == 0, 0, 100, 1'b0, 0, 0, 1'b0);
      if (j == 1) begin
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL t5_fault_clr got %b want 0", fault); end
      end
      if (j == 63) begin
        n_checks++;
        if (fault_ch !== 4'b0000) begin n_fail++; $display("FAIL t5_pre_timeout2 got %b want 0000", fault_ch); end
      end
      if (j == 64) begin
        n_checks++;
        if (fault_ch !== 4'b1110) begin n_fail++; $display("FAIL t5_timeout2 got %b want 1110", fault_ch); end
      end
      if (j == 65) begin
        n_checks++;
        if (fault !== 1'b1) begin n_fail++; $display("FAIL t5_fault2 got %b want 1", fault); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) smp(0, 200);
    n_checks++;
    if (alert_ch[0] !== 1'b0) begin n_fail++; $display("FAIL t6_pre got %b want 0", alert_ch[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (alert_ch !== 4'b0) begin n_fail++; $display("FAIL t6_alert_ch got %b want 0000", alert_ch); end
    if (alert_level !== 3'd0) begin n_fail++; $display("FAIL t6_level got %0d want 0", alert_level); end
    if (harvest_alert !== 1'b0) begin n_fail++; $display("FAIL t6_harvest got %b want 0", harvest_alert); end
    if (fault_ch !== 4'b0) begin n_fail++; $display("FAIL t6_fault_ch got %b want 0000", fault_ch); end
    if (fault !== 1'b0) begin n_fail++; $display("FAIL t6_fault got %b want 0", fault); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    smp(0, 200);
    n_checks++;
    if (alert_ch !== 4'b0000) begin n_fail++; $display("FAIL t6_restart got %b want 0000", alert_ch); end
    for (int i = 0; i < 3; i++) smp(0, 200);
    n_checks++;
    if (alert_ch !== 4'b0001) begin n_fail++; $display("FAIL t6_full_count got %b want 0001", alert_ch); end
  endtask

  task automatic test_random();
    int ch, d, cch, cth, r;
    logic v, we, clr;
    for (int i = 0; i < 2000; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      ch = (i >= 1000 && i < 1300) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 3));
      if (r == 0) d = int'($urandom_range(0, 255));
      else begin
        d = m_thr[ch] + int'($urandom_range(0, 16)) - 8;
        if (d < 0) d = 0;
        if (d > 255) d = 255;
      end
      we  = ($urandom_range(0, 19) == 0);
      cch = int'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: cth = int'($urandom_range(0, 3));
        1: cth = int'($urandom_range(250, 255));
        default: cth = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 49) == 0) cur_mode = ~cur_mode;
      clr = ($urandom_range(0, 149) == 0);
      cyc(v, ch, d, we, cch, cth, clr);
      n_checks += 5;
      if (alert_ch !== m_alert) begin n_fail++; $display("FAIL rnd_alert_ch cyc %0d got %b want %b", i, alert_ch, m_alert); end
      if (alert_level !== 3'(m_level)) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d want %0d", i, alert_level, m_level); end
      if (harvest_alert !== m_harvest) begin n_fail++; $display("FAIL rnd_harvest cyc %0d got %b want %b", i, harvest_alert, m_harvest); end
      if (fault_ch !== m_fault_ch) begin n_fail++; $display("FAIL rnd_fault_ch cyc %0d got %b want %b", i, fault_ch, m_fault_ch); end
      if (fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault cyc %0d got %b want %b", i, fault, m_fault); end
    end
  endtask

  initial begin
    test_reset();
    test_alert_basic();
    test_band_release();
    test_interrupted();
    test_config();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
